// File: rtl/instr_fetch.sv
// Instruction fetch front-end: byte-wide memory walker, big-endian word assembly and prefetch FIFO.
// Optional macro IFETCH_ALIGN_CHECK_EN: misaligned redirects set a sticky error and halt fetch until rst.
module instr_fetch #(
  parameter int M     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  output logic         mem_req,
  output logic [M-1:0] mem_addr,
  input  logic [7:0]   mem_rdata,
  input  logic         redirect,
  input  logic [M-1:0] redirect_pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [31:0]  instr,
  output logic [M-1:0] instr_pc,
  output logic         misaligned
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [M-1:0]  fetch_pc_q, fetch_pc_d;
  logic [1:0]    phase_q, phase_d;
  logic          busy_q, busy_d;
  logic          rd_pend_q, rd_pend_d;
  logic [1:0]    rd_idx_q, rd_idx_d;
  logic [23:0]   asm_q, asm_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   hold_word_q;
  logic [M-1:0]  hold_pc_q;

  logic [31:0]   fifo_word [DEPTH];
  logic [M-1:0]  fifo_pc   [DEPTH];

  logic          halt;
  logic          push;
  logic          wr_en;
  logic          pop;
  logic          room;
  logic          start;
  logic          issue;
  logic [M-1:0]  base_pc;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic misal_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      misal_q <= 1'b0;
    end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      misal_q <= 1'b1;
    end
  end

  assign halt       = misal_q;
  assign misaligned = misal_q;
`else
  logic unused_pc_lo;

  assign unused_pc_lo = ^redirect_pc[1:0];
  assign halt         = 1'b0;
  assign misaligned   = 1'b0;
`endif

  // Request side: the byte-3 return cycle already sees the next word's base PC
  always_comb begin
    push    = rd_pend_q && (rd_idx_q == 2'd3);
    wr_en   = push && !redirect;
    pop     = instr_valid && instr_ready;
    base_pc = push ? (fetch_pc_q + M'(4)) : fetch_pc_q;
    room    = (count_q + CW'(busy_q)) < CW'(DEPTH);
    start   = (phase_q == 2'd0) && room && !halt;
    issue   = (start || (phase_q != 2'd0)) && !halt && !rst;
  end

  assign mem_req  = issue;
  assign mem_addr = base_pc + M'(phase_q);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    phase_d    = phase_q;
    busy_d     = busy_q;
    rd_pend_d  = 1'b0;
    rd_idx_d   = rd_idx_q;
    asm_d      = asm_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    // Byte 3 bypasses the assembly register straight into the FIFO
    if (rd_pend_q) begin
      case (rd_idx_q)
        2'd0:    asm_d[23:16] = mem_rdata;
        2'd1:    asm_d[15:8]  = mem_rdata;
        2'd2:    asm_d[7:0]   = mem_rdata;
        default: ;
      endcase
    end

    if (issue) begin
      phase_d   = phase_q + 2'd1;
      rd_pend_d = 1'b1;
      rd_idx_d  = phase_q;
    end

    if (push) begin
      fetch_pc_d = fetch_pc_q + M'(4);
      busy_d     = 1'b0;
    end
    if (start && issue) begin
      busy_d = 1'b1;
    end

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: ;
    endcase

    if (redirect) begin
      fetch_pc_d = {redirect_pc[M-1:2], 2'b00};
      phase_d    = 2'd0;
      busy_d     = 1'b0;
      rd_pend_d  = 1'b0;
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= '0;
      phase_q    <= 2'd0;
      busy_q     <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_idx_q   <= 2'd0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      phase_q    <= phase_d;
      busy_q     <= busy_d;
      rd_pend_q  <= rd_pend_d;
      rd_idx_q   <= rd_idx_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    asm_q <= asm_d;
    if (wr_en) begin
      fifo_word[wr_ptr_q] <= {asm_q, mem_rdata};
      fifo_pc[wr_ptr_q]   <= fetch_pc_q;
    end
  end

  // Output side: the last shown head is kept so the outputs hold while empty
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_word_q <= '0;
      hold_pc_q   <= '0;
    end else if (instr_valid) begin
      hold_word_q <= fifo_word[rd_ptr_q];
      hold_pc_q   <= fifo_pc[rd_ptr_q];
    end
  end

  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? fifo_word[rd_ptr_q] : hold_word_q;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr_q]   : hold_pc_q;

endmodule
